// File: rtl/note_freq_engine.sv
// Multi-channel note-to-frequency engine: octave-0 base ROM shifted by octave,
// per-channel target/current frequency with optional portamento stepping.
module note_freq_engine #(
   parameter int CHANNELS    = 4,
   parameter int FREQ_W      = 20,
   parameter int GLIDE_SHIFT = 3
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_channel,
   input  logic [3:0]                 in_note,
   input  logic [2:0]                 in_octave,
   input  logic                       glide_en,
   input  logic                       glide_tick,
   output logic [CHANNELS*FREQ_W-1:0] freq_flat,
   output logic [CHANNELS-1:0]        settled,
   output logic                       done,
   output logic [3:0]                 done_channel,
   output logic                       done_err
);

   localparam logic [3:0] NOTE_OFF = 4'd15;

   function automatic logic [11:0] base_rom(input logic [3:0] note);
      logic [11:0] b;
      case (note)
         4'd0:    b = 12'd1635;
         4'd1:    b = 12'd1732;
         4'd2:    b = 12'd1835;
         4'd3:    b = 12'd1945;
         4'd4:    b = 12'd2060;
         4'd5:    b = 12'd2183;
         4'd6:    b = 12'd2312;
         4'd7:    b = 12'd2450;
         4'd8:    b = 12'd2596;
         4'd9:    b = 12'd2750;
         4'd10:   b = 12'd2914;
         4'd11:   b = 12'd3087;
         default: b = 12'd0;
      endcase
      return b;
   endfunction

   // step is never larger than the distance, so the result cannot overshoot
   function automatic logic [FREQ_W-1:0] glide_next(input logic [FREQ_W-1:0] cur,
                                                     input logic [FREQ_W-1:0] tgt);
      logic [FREQ_W-1:0] diff;
      logic [FREQ_W-1:0] step;
      diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
      step = diff >> GLIDE_SHIFT;
      if (step == '0) step = FREQ_W'(1);
      return (tgt > cur) ? (cur + step) : (cur - step);
   endfunction

   logic                ready_q;
   logic                s1_vld_q;
   logic                s1_err_q;
   logic [3:0]          s1_ch_q;
   logic [3:0]          s1_note_q;
   logic [2:0]          s1_oct_q;
   logic [11:0]         s1_rom_q;
   logic                done_q;
   logic                done_err_q;
   logic [3:0]          done_ch_q;
   logic [FREQ_W-1:0]   tgt_q [CHANNELS];
   logic [FREQ_W-1:0]   cur_q [CHANNELS];
   logic [FREQ_W-1:0]   tgt_d [CHANNELS];
   logic [FREQ_W-1:0]   cur_d [CHANNELS];
   logic                s0_fire;
   logic                s0_err;
   logic [FREQ_W-1:0]   s2_freq;

   assign s0_fire = in_valid & ready_q;
   assign s0_err  = (in_note inside {4'd12, 4'd13, 4'd14}) ||
                    ({1'b0, in_channel} >= 5'(CHANNELS));
   assign s2_freq = FREQ_W'(s1_rom_q) << s1_oct_q;

   // S2: channel write has priority over a glide step on the same channel
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         tgt_d[k] = tgt_q[k];
         cur_d[k] = cur_q[k];
         if (s1_vld_q && !s1_err_q && (s1_ch_q == 4'(k))) begin
            if (s1_note_q == NOTE_OFF) begin
               tgt_d[k] = '0;
               cur_d[k] = '0;
            end else begin
               tgt_d[k] = s2_freq;
               if (!glide_en || (cur_q[k] == '0)) cur_d[k] = s2_freq;
            end
         end else if (glide_en && glide_tick && (cur_q[k] != tgt_q[k])) begin
            cur_d[k] = glide_next(cur_q[k], tgt_q[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_ch_q    <= '0;
         s1_note_q  <= '0;
         s1_oct_q   <= '0;
         s1_rom_q   <= '0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
         done_ch_q  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            tgt_q[k] <= '0;
            cur_q[k] <= '0;
         end
      end else begin
         ready_q  <= 1'b1;
         // S1: registered request and ROM lookup
         s1_vld_q <= s0_fire;
         if (s0_fire) begin
            s1_err_q  <= s0_err;
            s1_ch_q   <= in_channel;
            s1_note_q <= in_note;
            s1_oct_q  <= in_octave;
            s1_rom_q  <= base_rom(in_note);
         end
         done_q     <= s1_vld_q;
         done_err_q <= s1_vld_q & s1_err_q;
         if (s1_vld_q) done_ch_q <= s1_ch_q;
         for (int k = 0; k < CHANNELS; k++) begin
            tgt_q[k] <= tgt_d[k];
            cur_q[k] <= cur_d[k];
         end
      end
   end

   always_comb begin
      freq_flat = '0;
      settled   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         freq_flat[k*FREQ_W +: FREQ_W] = cur_q[k];
         settled[k]                    = (cur_q[k] == tgt_q[k]);
      end
   end

   assign in_ready     = ready_q;
   assign done         = done_q;
   assign done_err     = done_err_q;
   assign done_channel = done_ch_q;

endmodule

// File: doc/note_freq_engine.md
# note_freq_engine

Multi-channel note-to-frequency engine for the synth voice path. It accepts note/octave requests tagged with a channel over a valid/ready port. It derives each frequency from a 12-entry octave-0 base table shifted left by the octave. It holds a per-channel target and current frequency, with optional portamento (glide) stepping on an external tick. It sits between the key/sequencer front end and the per-voice oscillators, which read `freq_flat`.

## Interface
- `CHANNELS`, 4, number of independent voices (1..16)
- `FREQ_W`, 20, frequency width; fixed point, 2 fractional decimal digits (1635 = 16.35 Hz)
- `GLIDE_SHIFT`, 3, glide step = |target − current| >> GLIDE_SHIFT, minimum 1
- `clk  in  1  system clock`
- `resetn  in  1  synchronous, active-low reset`
- `in_valid  in  1  request valid`
- `in_ready  out  1  engine can accept request`
- `in_channel  in  4  target channel`
- `in_note  in  4  0=C … 11=B; 15=note-off; 12–14 illegal`
- `in_octave  in  3  octave 0..7`
- `glide_en  in  1  1: current glides toward target; 0: current jumps`
- `glide_tick  in  1  one-cycle strobe advancing all gliding channels by one step`
- `freq_flat  out  CHANNELS*FREQ_W  current frequency; channel k at bits [k*FREQ_W +: FREQ_W]`
- `settled  out  CHANNELS  bit k = 1 when current[k] == target[k]`
- `done  out  1  one-cycle pulse, request processed`
- `done_channel  out  4  channel of processed request`
- `done_err  out  1  with done: request rejected`

## Operation
- Base ROM (octave 0, centi-Hz): 1635, 1732, 1835, 1945, 2060, 2183, 2312, 2450, 2596, 2750, 2914, 3087.
- Frequency = base[note] << octave, zero-extended to FREQ_W. The maximum is 395136, so 19 bits are sufficient.
- Pipeline:
  - S0: the handshake fires on `in_valid & in_ready`.
  - S1: registered note, octave, channel, ROM output, and error flag.
  - S2: target/current write plus the `done` pulse.
- Error when `in_note` is 12–14 or `in_channel >= CHANNELS`:
  - The request still flows through the pipeline.
  - No register changes.
  - `done=1`, `done_err=1`.
- Note-off (15): target and current of that channel are set to 0 immediately, regardless of `glide_en`.
- Valid note write:
  - Target ← freq.
  - If `glide_en=0`, or the channel's current value is 0 (silent), current ← freq in the same cycle.
  - Otherwise current is left unchanged and glides.
- Glide, on `glide_tick`, for every channel with current ≠ target:
  - step = max(1, |target − current| >> GLIDE_SHIFT).
  - Current moves toward target by step and never overshoots.
  - When `glide_en=0`, `glide_tick` is ignored. Unsettled channels hold their value until the next write or until `glide_en` returns to 1.
- Simultaneous write (S2) and `glide_tick`:
  - The written channel takes the write and does not step that cycle.
  - All other channels step normally.
- `settled` is combinational from the current and target registers.

## Timing
- Reset, synchronous active-low, sampled at the rising edge:
  - All targets, currents, and pipeline registers are 0.
  - `freq_flat=0`, `settled` all 1.
  - `done=0`, `done_err=0`, `done_channel=0`.
  - `in_ready=0` while `resetn=0`, and 1 from the first cycle after release.
- Reset during glide or with a request in flight: the request is discarded, no `done` is issued, and all state clears.
- `in_ready` is 1 continuously out of reset. Throughput is one request per cycle.
- Latency: handshake at edge E; S1 registered at E; S2 write and `done` asserted from edge E+1, high for exactly one cycle.
- With `glide_en=0`, `freq_flat` shows the new value from edge E+1.
- Back-to-back requests to the same channel: the later one wins, in order, one cycle apart.
- Each `glide_tick` registered at edge T updates current from edge T.

## Test plan
- Reset then lookup, `glide_en=0`: ch1 note 9 oct 4 → `done` at E+1, `done_channel=1`, `done_err=0`, ch1 freq = 44000, `settled[1]=1`. Also ch0 C0 → 1635 and ch2 B7 → 395136.
- Glide, GLIDE_SHIFT=3 overridden to 2:
  - Setup: ch0 at 1635 settled, `glide_en=1`, request ch0 note 0 oct 1 → target 3270, current stays 1635, `settled[0]=0`.
  - Ticks: current goes 2043, then 2349, and continues until exactly 3270, then `settled[0]=1`.
  - Final steps of 1 must not overshoot.
- Errors: note 13 on ch0, and channel 5 with CHANNELS=4 → `done_err=1`, `freq_flat` unchanged.
- Note-off while gliding: ch0 mid-glide at 2349, note 15 → ch0 current = target = 0 at E+1. A subsequent `glide_en=1` note on ch0 jumps directly to its frequency because ch0 is silent.
- Collision: `glide_tick` in the same cycle as an S2 write to ch0 while ch1 glides → ch0 takes the written value, ch1 steps once. Also check a 4-cycle stream of back-to-back requests, which must produce 4 consecutive `done` pulses.
- Reset mid-operation: assert `resetn=0` with ch0 gliding and a request in S1 → no `done`, all outputs zero, `settled` all 1, `in_ready=0` during reset.
